// File: rtl/sum_to_minifloat.sv
// rtl/sum_to_minifloat.sv - packs a signed fixed-point sum into {sign, exp[3:0], mant[2:0]} minifloat
// Leading-one search shifts one bit per cycle; mantissa bits below the top three are truncated.
module sum_to_minifloat #(
  parameter int IN_W = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_sum,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_float,
  output logic            out_ovf
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t          state;
  logic            sign;
  logic [IN_W-1:0] mag;
  logic [4:0]      cnt;
  logic [IN_W-1:0] abs_sum;
  logic [5:0]      e;

  // Unsigned IN_W-bit result, so the most negative input maps to 2^(IN_W-1) without wrapping.
  assign abs_sum  = in_sum[IN_W-1] ? ((~in_sum) + {{(IN_W-1){1'b0}}, 1'b1}) : in_sum;
  // e = p + 1 = IN_W - cnt, kept at 6 bits so the overflow compare never wraps.
  assign e        = 6'(IN_W) - {1'b0, cnt};
  assign in_ready = (state == IDLE) && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sign      <= 1'b0;
      mag       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_float <= 8'h00;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign  <= in_sum[IN_W-1];
            mag   <= abs_sum;
            cnt   <= '0;
            state <= NORM;
          end
        end
        NORM: begin
          if (mag == '0) begin
            out_float <= 8'h00;
            out_ovf   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (mag[IN_W-1]) begin
            if (e > 6'd15) begin
              out_float <= {sign, 7'h7F};
              out_ovf   <= 1'b1;
            end else begin
              out_float <= {sign, e[3:0], mag[IN_W-2 -: 3]};
              out_ovf   <= 1'b0;
            end
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            mag <= mag << 1;
            cnt <= cnt + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_to_minifloat.sv
// tb/tb_sum_to_minifloat.sv - scoreboard bench for sum_to_minifloat
// Expected words come from an independent arithmetic model queued at each accepted input.
module tb_sum_to_minifloat;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_float;
  logic        out_ovf;

  typedef struct {
    int         val;
    logic [7:0] flt;
    logic       ovf;
    int         lat;
    bit         chk_lat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  sum_to_minifloat #(.IN_W(17)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_float (out_float),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int v);
    exp_t r;
    int   m;
    int   p;
    int   mant;
    logic s;
    r.val = v;
    s = (v < 0);
    m = (v < 0) ? -v : v;
    if (m == 0) begin
      r.flt = 8'h00; r.ovf = 1'b0; r.lat = 2; r.chk_lat = 1'b1;
      return r;
    end
    p = 0;
    for (int b = 0; b < 17; b++) if ((m >> b) & 1) p = b;
    r.lat = (16 - p) + 2;
    if (p >= 15) begin
      r.flt = {s, 7'h7F}; r.ovf = 1'b1; r.chk_lat = (p == 16);
    end else begin
      mant = (p >= 3) ? ((m >> (p - 3)) & 7) : ((m << (3 - p)) & 7);
      r.flt = {s, 4'(p + 1), 3'(mant)}; r.ovf = 1'b0; r.chk_lat = 1'b1;
    end
    return r;
  endfunction

  task automatic send(input int v);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk); n++;
    end
    total++;
    if (!in_ready) begin
      bad++; $display("FAIL send_ready: in_ready=%0b required 1 for value %0d", in_ready, v);
    end
    in_valid = 1'b1;
    in_sum   = 17'(v);
    @(posedge clk);
    exp_q.push_back(model(v));
    #1 in_valid = 1'b0;
  endtask

  // Called right after the accepting edge; counts edges until out_valid appears.
  task automatic receive();
    exp_t x;
    int   n = 0;
    bit   seen = 0;
    while (n < 40 && !seen) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL recv_timeout: out_valid=0 after %0d cycles, required 1", n);
      return;
    end
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL recv_unexpected: out_float=%h with empty scoreboard", out_float);
      return;
    end
    x = exp_q.pop_front();
    total++;
    if (out_float !== x.flt) begin
      bad++; $display("FAIL float(%0d): got %h required %h", x.val, out_float, x.flt);
    end
    total++;
    if (out_ovf !== x.ovf) begin
      bad++; $display("FAIL ovf(%0d): got %b required %b", x.val, out_ovf, x.ovf);
    end
    if (x.chk_lat) begin
      total++;
      if (n + 1 != x.lat) begin
        bad++; $display("FAIL latency(%0d): got %0d required %0d", x.val, n + 1, x.lat);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL out_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_float !== 8'h00 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: valid=%b float=%h ovf=%b ready=%b required 0/00/0/0",
               out_valid, out_float, out_ovf, in_ready);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_table();
    int vals[$] = '{0, 1, 13, 15, -100, 30720, 32767, 32768, -65536, -32768, 65535, -1, 8, -9, 4095};
    foreach (vals[i]) begin
      send(vals[i]);
      receive();
    end
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 12; i++) begin
      v = int'($urandom_range(0, 131071)) - 65536;
      send(v);
      receive();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] held;
    send(-100);
    receive();
    send(13);
    send_pending_check();
    held = out_float;
    in_valid = 1'b1;
    in_sum   = 17'(15);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_float !== held || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure[%0d]: valid=%b float=%h ready=%b required 1/%h/0",
                 i, out_valid, out_float, in_ready, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    exp_q.pop_front();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    @(posedge clk);
    exp_q.push_back(model(15));
    #1 in_valid = 1'b0;
    receive();
  endtask

  // Waits for the 13 result to be presented, checking it, and leaves it un-acknowledged.
  task automatic send_pending_check();
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk); n++;
    end
    total++;
    if (out_valid !== 1'b1 || out_float !== 8'h25) begin
      bad++; $display("FAIL bp_first: valid=%b float=%h required 1/25", out_valid, out_float);
    end
  endtask

  task automatic test_reset_mid();
    send(1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset: in_ready=%b out_valid=%b required 0/0", in_ready, out_valid);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL mid_reset_drop[%0d]: out_valid=%b required 0", i, out_valid);
      end
    end
    send(-100);
    receive();
  endtask

  initial begin
    test_reset();
    test_table();
    test_random();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_left: %0d entries required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
